// File: rtl/init_if.sv
// Memory-write port of the S-array initialiser: start request, ready flag
// and the byte-wide write bus.
interface init_if;
  logic       en;
  logic       rdy;
  logic [7:0] addr;
  logic [7:0] wrdata;
  logic       wren;

  modport master (
    input  en,
    output rdy,
    output addr,
    output wrdata,
    output wren
  );

  modport slave (
    output en,
    input  rdy,
    input  addr,
    input  wrdata,
    input  wren
  );
endinterface

// File: rtl/init.sv
// Fills a 256-byte memory with the identity permutation mem[i] = i,
// one ascending write per clock once a start request is accepted.
module init (
  input  logic clk,
  input  logic rst_n,
  init_if.master bus
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] count;
  logic [7:0] count_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  // Terminal count at 255 ends the fill, so the counter never wraps into a 257th write.
  always_comb begin
    state_next = state;
    count_next = count;
    case (state)
      IDLE: begin
        count_next = '0;
        if (bus.en) begin
          state_next = FILL;
        end
      end
      FILL: begin
        if (count == 8'hFF) begin
          state_next = IDLE;
          count_next = '0;
        end else begin
          count_next = count + 8'd1;
        end
      end
    endcase
  end

  assign bus.rdy    = (state == IDLE);
  assign bus.wren   = (state == FILL);
  assign bus.addr   = count;
  assign bus.wrdata = count;

endmodule

// File: tb/tb_init.sv
// Directed self-checking bench for the identity-permutation initialiser.
module tb_init;

  logic clk = 1'b0;
  logic rst_n;
  int   tests_run    = 0;
  int   tests_failed = 0;

  init_if bus ();

  init dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Observed word is {rdy, wren, addr, wrdata}.
  task automatic test_reset;
    logic [17:0] got;
    logic [17:0] exp;
    rst_n  = 1'b0;
    bus.en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    got = {bus.rdy, bus.wren, bus.addr, bus.wrdata};
    exp = {1'b1, 1'b0, 8'd0, 8'd0};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL reset_held: got %h expected %h", got, exp);
    end
    rst_n = 1'b1;
    @(negedge clk);
    got = {bus.rdy, bus.wren, bus.addr, bus.wrdata};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL reset_release: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_single_fill;
    logic [17:0] got;
    logic [17:0] exp;
    logic [7:0]  a;
    bus.en = 1'b1;
    @(posedge clk);
    #1 bus.en = 1'b0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      a   = 8'(i);
      got = {bus.rdy, bus.wren, bus.addr, bus.wrdata};
      exp = {1'b0, 1'b1, a, a};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("[TB] FAIL single_fill[%0d]: got %h expected %h", i, got, exp);
      end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      got = {bus.rdy, bus.wren, bus.addr, bus.wrdata};
      exp = {1'b1, 1'b0, 8'd0, 8'd0};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("[TB] FAIL idle_after_fill[%0d]: got %h expected %h", k, got, exp);
      end
    end
  endtask

  task automatic test_en_during_fill;
    logic [17:0] got;
    logic [17:0] exp;
    logic [7:0]  a;
    int          writes;
    writes = 0;
    bus.en = 1'b1;
    @(posedge clk);
    #1 bus.en = 1'b0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (bus.wren === 1'b1) writes++;
      a   = 8'(i);
      got = {bus.rdy, bus.wren, bus.addr, bus.wrdata};
      exp = {1'b0, 1'b1, a, a};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("[TB] FAIL en_in_fill[%0d]: got %h expected %h", i, got, exp);
      end
      if (i == 100) bus.en = 1'b1;
      if (i == 101) bus.en = 1'b0;
    end
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.wren === 1'b1) writes++;
    end
    tests_run++;
    if (writes != 256) begin
      tests_failed++;
      $display("[TB] FAIL en_in_fill_count: got %0d writes expected 256", writes);
    end
    got = {bus.rdy, bus.wren, bus.addr, bus.wrdata};
    exp = {1'b1, 1'b0, 8'd0, 8'd0};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL en_in_fill_end: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_reset_mid_fill;
    logic [17:0] got;
    logic [17:0] exp;
    logic [7:0]  a;
    bus.en = 1'b1;
    @(posedge clk);
    #1 bus.en = 1'b0;
    for (int i = 0; i <= 50; i++) begin
      @(negedge clk);
      a   = 8'(i);
      got = {bus.rdy, bus.wren, bus.addr, bus.wrdata};
      exp = {1'b0, 1'b1, a, a};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("[TB] FAIL pre_abort[%0d]: got %h expected %h", i, got, exp);
      end
    end
    // Between clock edges, so only an asynchronous reset can take effect.
    #1 rst_n = 1'b0;
    #1;
    got = {bus.rdy, bus.wren, bus.addr, bus.wrdata};
    exp = {1'b1, 1'b0, 8'd0, 8'd0};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL async_abort: got %h expected %h", got, exp);
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    got = {bus.rdy, bus.wren, bus.addr, bus.wrdata};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL post_abort_idle: got %h expected %h", got, exp);
    end
    bus.en = 1'b1;
    @(posedge clk);
    #1 bus.en = 1'b0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      a   = 8'(i);
      got = {bus.rdy, bus.wren, bus.addr, bus.wrdata};
      exp = {1'b0, 1'b1, a, a};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("[TB] FAIL refill[%0d]: got %h expected %h", i, got, exp);
      end
    end
    @(negedge clk);
    got = {bus.rdy, bus.wren, bus.addr, bus.wrdata};
    exp = {1'b1, 1'b0, 8'd0, 8'd0};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL refill_end: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_back_to_back;
    logic [17:0] got;
    logic [17:0] exp;
    logic [7:0]  a;
    bus.en = 1'b1;
    @(posedge clk);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 256; i++) begin
        @(negedge clk);
        a   = 8'(i);
        got = {bus.rdy, bus.wren, bus.addr, bus.wrdata};
        exp = {1'b0, 1'b1, a, a};
        tests_run++;
        if (got !== exp) begin
          tests_failed++;
          $display("[TB] FAIL b2b_fill%0d[%0d]: got %h expected %h", f, i, got, exp);
        end
      end
      if (f == 1) bus.en = 1'b0;
      @(negedge clk);
      got = {bus.rdy, bus.wren, bus.addr, bus.wrdata};
      exp = {1'b1, 1'b0, 8'd0, 8'd0};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("[TB] FAIL b2b_gap%0d: got %h expected %h", f, got, exp);
      end
    end
    @(negedge clk);
    got = {bus.rdy, bus.wren, bus.addr, bus.wrdata};
    exp = {1'b1, 1'b0, 8'd0, 8'd0};
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL b2b_final_idle: got %h expected %h", got, exp);
    end
  endtask

  initial begin
    test_reset;
    test_single_fill;
    test_en_during_fill;
    test_reset_mid_fill;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/init.md
INIT -- requirements
Module: init

Interface
REQ-001 Parameters: none; address and data widths are fixed at 8 bits (256-entry S array).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 en  input  1  start request; honoured only when rdy=1.
REQ-005 rdy  output  1  1 = idle and able to accept en; 0 = busy.
REQ-006 addr  output  8  memory write address.
REQ-007 wrdata  output  8  memory write data.
REQ-008 wren  output  1  memory write enable; one write per cycle with wren=1.

Function
REQ-009 The block SHALL fill a 256-byte memory with the identity permutation: mem[i]=i for i=0..255, in ascending order.
REQ-010 All outputs SHALL be driven from registers (no combinational path from en to any output).
REQ-011 The state machine SHALL have exactly two states: IDLE (rdy=1, wren=0) and FILL (rdy=0, wren=1).
REQ-012 IDLE -> FILL SHALL occur on the rising edge where en=1 and rdy=1; the internal 8-bit counter is cleared to 0 on that edge.
REQ-013 In FILL, on each cycle addr SHALL equal the counter, wrdata SHALL equal addr, and wren SHALL be 1.
REQ-014 The counter SHALL increment by 1 per cycle in FILL; no stalls and no skipped or repeated addresses.
REQ-015 The first write (addr=0) SHALL be presented in the cycle immediately after the en-accepting edge; the last write (addr=255) exactly 256 cycles after that edge.
REQ-016 After the edge that completes the addr=255 write, the FSM SHALL return to IDLE: rdy=1, wren=0 in the next cycle.
REQ-017 The wrap of the counter from 255 to 0 SHALL be detected explicitly (terminal-count compare on 255 or a 9th carry bit); it SHALL NOT cause an extra write.
REQ-018 en asserted while in FILL SHALL be ignored; the sequence is neither restarted nor extended.
REQ-019 en held high continuously in IDLE SHALL start a new fill; back-to-back fills are permitted, with exactly one IDLE cycle between them.
REQ-020 rdy SHALL never be 1 in a cycle where wren=1.
REQ-021 In IDLE, addr and wrdata SHALL hold 0.
REQ-022 A complete fill SHALL produce exactly 256 wren=1 cycles.

Reset
REQ-023 While rst_n=0 the block SHALL be in IDLE: rdy=1, wren=0, addr=0, wrdata=0, counter=0, independent of clk.
REQ-024 Reset asserted mid-FILL SHALL abort immediately (asynchronously): wren drops to 0 and rdy rises to 1 without waiting for a clock edge.
REQ-025 After rst_n deasserts, the block SHALL accept en on the first rising edge at which en=1.

Verification
REQ-026 Reset 3 cycles, release; sample -> rdy=1, wren=0, addr=0.
REQ-027 Pulse en for 1 cycle -> 256 consecutive cycles with wren=1 and addr=wrdata=0,1,...,255; rdy=0 throughout; then rdy=1.
REQ-028 After completion, monitor 3+ cycles with en=0 -> wren=0, rdy=1 in every cycle.
REQ-029 Pulse en again at write addr=100 -> sequence continues 101..255 unchanged; total write count is 256.
REQ-030 Assert rst_n=0 at write addr=50 -> wren=0 and rdy=1 immediately; after release, pulse en -> fresh fill starting at addr=0.
REQ-031 Hold en=1 continuously -> two full fills separated by exactly one cycle with rdy=1, wren=0.
